// File: rtl/rca_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package rca_pkg;

    localparam int NIBBLE_W = 4;

    // 2'd3 is unused; the adder treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca.sv
// Purely combinational 4-bit ripple-carry adder core.
module rca
    import rca_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/rca_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple-carry core, one nibble per cycle,
// LSB first, with valid/ready handshakes on operands and result.
module rca_serial_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               c_out_reg;

    logic [NIBBLE_W-1:0] rca_s;
    logic                rca_c;
    logic [WIDTH-1:0]    sum_next;

    rca u_rca (
        .a     (a_sh_reg[NIBBLE_W-1:0]),
        .b     (b_sh_reg[NIBBLE_W-1:0]),
        .c_in  (carry_reg),
        .s     (rca_s),
        .c_out (rca_c)
    );

    // New nibble enters at the top, so after NIB steps nibble 0 sits at the bottom.
    assign sum_next = WIDTH'({rca_s, sum_reg} >> NIBBLE_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ADD: begin
                    a_sh_reg  <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg  <= b_sh_reg >> NIBBLE_W;
                    sum_reg   <= sum_next;
                    carry_reg <= rca_c;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(NIB - 1)) begin
                        c_out_reg <= rca_c;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= c_in;
                        cnt_reg   <= '0;
                        state_reg <= ST_ADD;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_reg != ST_ADD) && (state_reg != ST_DONE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_ADD) || (state_reg == ST_DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;

endmodule

// File: tb/tb_rca_serial_adder.sv
// Self-checking bench for rca_serial_adder: cycle-level reference model plus
// directed vectors with literal expected results.
module tb_rca_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    rca_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result presented.
    int          cyc     = 0;
    int          m_phase = 0;
    int          m_left  = 0;
    logic [16:0] m_pend  = '0;
    logic [16:0] m_res   = '0;
    bit          m_live  = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_res   = '0;
            m_live  = 1;
        end else if (m_live) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  = {1'b0, a} + {1'b0, b} + 17'(c_in);
                    m_left  = NIB;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_res   = m_pend;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    bit spacing_on = 0;
    int d_last     = -1;
    int n_acc      = 0;

    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase != 1) begin
                chk("sum", sum, m_res[15:0]);
                chk("c_out", c_out, m_res[16]);
            end
            if (spacing_on && in_valid && in_ready) begin
                if (d_last >= 0) chk("accept_spacing", cyc - d_last, 6);
                d_last = cyc;
                n_acc++;
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input int hold, output logic [15:0] rs, output logic rc,
                          output int lat);
        int n;
        int acc;
        @(posedge clk);
        #1;
        a = ta; b = tb_v; c_in = tc; in_valid = 1'b1; out_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = ~ta; b = ~tb_v; c_in = ~tc;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
        lat = cyc - acc - 1;
        rs  = sum;
        rc  = c_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a = 16'h0F0F; b = 16'h7777; c_in = 1'b1;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_sum", sum, rs);
            chk("hold_c_out", c_out, rc);
            chk("hold_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("release_idle", in_ready, 1);
        end
    endtask

    logic [15:0] rs;
    logic        rc;
    int          lat;
    int          guard;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_c_out", c_out, 0);

        run_op(16'h1234, 16'h4321, 1'b0, 0, rs, rc, lat);
        chk("t1_sum", rs, 16'h5555);
        chk("t1_c_out", rc, 0);
        chk("t1_latency", lat, 4);

        run_op(16'hFFFF, 16'h0000, 1'b1, 0, rs, rc, lat);
        chk("t2_sum", rs, 16'h0000);
        chk("t2_c_out", rc, 1);

        run_op(16'h8000, 16'h8000, 1'b0, 0, rs, rc, lat);
        chk("t3_sum", rs, 16'h0000);
        chk("t3_c_out", rc, 1);

        run_op(16'h00FF, 16'h0F01, 1'b0, 5, rs, rc, lat);
        chk("t4_sum", rs, 16'h1000);
        chk("t4_c_out", rc, 0);

        // Abort an op in its second ADD cycle.
        @(posedge clk);
        #1;
        a = 16'h0005; b = 16'h0006; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("t5_idle_before", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_sum", sum, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, rs, rc, lat);
        chk("t5_next_sum", rs, 16'h0002);
        chk("t5_next_c_out", rc, 0);

        // Back-to-back random ops with in_valid held high.
        @(posedge clk);
        #1;
        spacing_on = 1; d_last = -1; n_acc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (n_acc < 1000 && guard < 7000) begin
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
            @(posedge clk);
            #1;
            guard++;
        end
        chk("t6_ops", n_acc, 1000);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        spacing_on = 0;
        @(negedge clk);
        chk("t6_final_idle", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
